// File: rtl/ctrl_pipeline_if.sv
// ID-side control bundle and pipeline control outputs of the MIPS control path.
// The master modport drives the decoded ID bundle; the slave modport is the pipeline.
interface ctrl_pipeline_if #(
  parameter int unsigned CNT_W = 16
);
  logic             id_valid;
  logic             id_reg_dst;
  logic             id_branch;
  logic             id_mem_read;
  logic             id_mem_2_reg;
  logic             id_mem_write;
  logic             id_alu_src;
  logic             id_reg_write;
  logic             id_jump;
  logic [1:0]       id_alu_op;
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic [4:0]       id_rd;
  logic             mem_zero;

  logic [1:0]       ex_alu_op;
  logic             ex_alu_src;
  logic             ex_mem_read;
  logic [4:0]       ex_wreg;
  logic             mem_branch;
  logic             mem_mem_read;
  logic             mem_mem_write;
  logic [4:0]       mem_wreg;
  logic             wb_reg_write;
  logic             wb_mem_2_reg;
  logic [4:0]       wb_wreg;
  logic             stall;
  logic             flush_if_id;
  logic             pc_src;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_valid, id_reg_dst, id_branch, id_mem_read, id_mem_2_reg, id_mem_write,
           id_alu_src, id_reg_write, id_jump, id_alu_op, id_rs, id_rt, id_rd, mem_zero,
    input  ex_alu_op, ex_alu_src, ex_mem_read, ex_wreg, mem_branch, mem_mem_read,
           mem_mem_write, mem_wreg, wb_reg_write, wb_mem_2_reg, wb_wreg, stall,
           flush_if_id, pc_src, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_valid, id_reg_dst, id_branch, id_mem_read, id_mem_2_reg, id_mem_write,
           id_alu_src, id_reg_write, id_jump, id_alu_op, id_rs, id_rt, id_rd, mem_zero,
    output ex_alu_op, ex_alu_src, ex_mem_read, ex_wreg, mem_branch, mem_mem_read,
           mem_mem_write, mem_wreg, wb_reg_write, wb_mem_2_reg, wb_wreg, stall,
           flush_if_id, pc_src, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/ctrl_pipeline.sv
// ID/EX, EX/MEM and MEM/WB control registers with load-use stall, branch/jump
// flush generation and saturating stall/flush event counters.
module ctrl_pipeline #(
  parameter int unsigned CNT_W = 16
) (
  input  logic          clk,
  input  logic          arst_n,
  input  logic          enable,
  ctrl_pipeline_if.slave bus
);
  // Controls carried down the pipe that are not visible as outputs.
  logic ex_branch;
  logic ex_mem_write;
  logic ex_reg_write;
  logic ex_mem_2_reg;
  logic mem_reg_write;
  logic mem_mem_2_reg;

  logic hazard;
  logic id_bubble;

  always_comb begin
    hazard = bus.ex_mem_read && (bus.ex_wreg != '0) && bus.id_valid && !bus.id_jump &&
             ((bus.ex_wreg == bus.id_rs) ||
              ((bus.ex_wreg == bus.id_rt) && (!bus.id_alu_src || bus.id_mem_write)));
    bus.pc_src      = bus.mem_branch & bus.mem_zero;
    bus.stall       = hazard & ~bus.pc_src;
    bus.flush_if_id = bus.pc_src | (bus.id_valid & bus.id_jump & ~bus.stall);
    id_bubble       = !bus.id_valid || bus.stall || bus.pc_src;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      bus.ex_alu_op     <= '0;
      bus.ex_alu_src    <= 1'b0;
      bus.ex_mem_read   <= 1'b0;
      bus.ex_wreg       <= '0;
      ex_branch         <= 1'b0;
      ex_mem_write      <= 1'b0;
      ex_reg_write      <= 1'b0;
      ex_mem_2_reg      <= 1'b0;
      bus.mem_branch    <= 1'b0;
      bus.mem_mem_read  <= 1'b0;
      bus.mem_mem_write <= 1'b0;
      bus.mem_wreg      <= '0;
      mem_reg_write     <= 1'b0;
      mem_mem_2_reg     <= 1'b0;
      bus.wb_reg_write  <= 1'b0;
      bus.wb_mem_2_reg  <= 1'b0;
      bus.wb_wreg       <= '0;
      bus.stall_cnt     <= '0;
      bus.flush_cnt     <= '0;
    end else if (enable) begin
      if (id_bubble) begin
        bus.ex_alu_op   <= '0;
        bus.ex_alu_src  <= 1'b0;
        bus.ex_mem_read <= 1'b0;
        bus.ex_wreg     <= '0;
        ex_branch       <= 1'b0;
        ex_mem_write    <= 1'b0;
        ex_reg_write    <= 1'b0;
        ex_mem_2_reg    <= 1'b0;
      end else begin
        bus.ex_alu_op   <= bus.id_alu_op;
        bus.ex_alu_src  <= bus.id_alu_src;
        bus.ex_mem_read <= bus.id_mem_read;
        bus.ex_wreg     <= bus.id_reg_dst ? bus.id_rd : bus.id_rt;
        ex_branch       <= bus.id_branch;
        ex_mem_write    <= bus.id_mem_write;
        ex_reg_write    <= bus.id_reg_write;
        ex_mem_2_reg    <= bus.id_mem_2_reg;
      end

      // A taken branch in MEM squashes the instruction currently in EX.
      if (bus.pc_src) begin
        bus.mem_branch    <= 1'b0;
        bus.mem_mem_read  <= 1'b0;
        bus.mem_mem_write <= 1'b0;
        bus.mem_wreg      <= '0;
        mem_reg_write     <= 1'b0;
        mem_mem_2_reg     <= 1'b0;
      end else begin
        bus.mem_branch    <= ex_branch;
        bus.mem_mem_read  <= bus.ex_mem_read;
        bus.mem_mem_write <= ex_mem_write;
        bus.mem_wreg      <= bus.ex_wreg;
        mem_reg_write     <= ex_reg_write;
        mem_mem_2_reg     <= ex_mem_2_reg;
      end

      bus.wb_reg_write <= mem_reg_write;
      bus.wb_mem_2_reg <= mem_mem_2_reg;
      bus.wb_wreg      <= bus.mem_wreg;

      if (bus.stall && (bus.stall_cnt != '1))
        bus.stall_cnt <= bus.stall_cnt + 1'b1;
      if (bus.flush_if_id && (bus.flush_cnt != '1))
        bus.flush_cnt <= bus.flush_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_ctrl_pipeline.sv
// Directed bench for ctrl_pipeline with 2-bit counters so saturation is reachable.
module tb_ctrl_pipeline;
  logic clk;
  logic arst_n;
  logic enable;
  int   checks;
  int   errors;

  ctrl_pipeline_if #(.CNT_W(2)) bus ();

  ctrl_pipeline #(.CNT_W(2)) dut (
    .clk    (clk),
    .arst_n (arst_n),
    .enable (enable),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic valid, input logic reg_dst, input logic branch,
                        input logic mem_read, input logic mem_2_reg, input logic mem_write,
                        input logic alu_src, input logic reg_write, input logic jump,
                        input logic [1:0] alu_op, input logic [4:0] rs,
                        input logic [4:0] rt, input logic [4:0] rd);
    bus.id_valid     = valid;
    bus.id_reg_dst   = reg_dst;
    bus.id_branch    = branch;
    bus.id_mem_read  = mem_read;
    bus.id_mem_2_reg = mem_2_reg;
    bus.id_mem_write = mem_write;
    bus.id_alu_src   = alu_src;
    bus.id_reg_write = reg_write;
    bus.id_jump      = jump;
    bus.id_alu_op    = alu_op;
    bus.id_rs        = rs;
    bus.id_rt        = rt;
    bus.id_rd        = rd;
  endtask

  task automatic nop();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 5'd0, 5'd0, 5'd0);
  endtask

  task automatic lw(input logic [4:0] rt);
    set_id(1, 0, 0, 1, 1, 0, 1, 1, 0, 2'd0, 5'd1, rt, 5'd0);
  endtask

  task automatic add(input logic [4:0] rs, input logic [4:0] rd);
    set_id(1, 1, 0, 0, 0, 0, 0, 1, 0, 2'd2, rs, 5'd3, rd);
  endtask

  task automatic beq();
    set_id(1, 0, 1, 0, 0, 0, 0, 0, 0, 2'd1, 5'd1, 5'd2, 5'd0);
  endtask

  task automatic jmp();
    set_id(1, 0, 0, 0, 0, 0, 0, 0, 1, 2'd0, 5'd0, 5'd0, 5'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    arst_n = 1'b0;
    enable = 1'b1;
    bus.mem_zero = 1'b0;
    nop();
    #3;
    chk("rst_ex_alu_op", bus.ex_alu_op, 0);
    chk("rst_stall", bus.stall, 0);
    chk("rst_flush", bus.flush_if_id, 0);
    chk("rst_pc_src", bus.pc_src, 0);
    chk("rst_stall_cnt", bus.stall_cnt, 0);
    chk("rst_flush_cnt", bus.flush_cnt, 0);
    @(negedge clk);
    arst_n = 1'b1;

    // R-type add rd=9 traversing the three stages
    add(5'd1, 5'd9);
    step();
    chk("add_ex_wreg", bus.ex_wreg, 9);
    chk("add_ex_alu_op", bus.ex_alu_op, 2);
    nop();
    step();
    chk("add_mem_wreg", bus.mem_wreg, 9);
    chk("add_ex_cleared", bus.ex_wreg, 0);
    step();
    chk("add_wb_wreg", bus.wb_wreg, 9);
    chk("add_wb_reg_write", bus.wb_reg_write, 1);

    // lw r8 then add using r8
    lw(5'd8);
    step();
    chk("lw_ex_mem_read", bus.ex_mem_read, 1);
    chk("lw_ex_wreg", bus.ex_wreg, 8);
    add(5'd8, 5'd10);
    #1;
    chk("lu_stall", bus.stall, 1);
    chk("lu_flush", bus.flush_if_id, 0);
    step();
    chk("lu_bubble_mem_read", bus.ex_mem_read, 0);
    chk("lu_bubble_wreg", bus.ex_wreg, 0);
    chk("lu_bubble_alu_op", bus.ex_alu_op, 0);
    chk("lu_stall_cnt", bus.stall_cnt, 1);
    chk("lu_stall_released", bus.stall, 0);
    chk("lu_lw_in_mem", bus.mem_mem_read, 1);
    step();
    chk("lu_add_ex_wreg", bus.ex_wreg, 10);
    chk("lu_add_ex_alu_op", bus.ex_alu_op, 2);
    chk("lu_stall_cnt_hold", bus.stall_cnt, 1);

    // lw to r0 never stalls
    lw(5'd0);
    step();
    add(5'd0, 5'd10);
    #1;
    chk("r0_no_stall", bus.stall, 0);
    step();
    nop();
    step();

    // taken beq in MEM while ID holds a jump
    beq();
    step();
    add(5'd1, 5'd11);
    step();
    chk("beq_mem_branch", bus.mem_branch, 1);
    jmp();
    bus.mem_zero = 1'b1;
    #1;
    chk("br_pc_src", bus.pc_src, 1);
    chk("br_flush", bus.flush_if_id, 1);
    chk("br_flush_cnt_before", bus.flush_cnt, 0);
    step();
    chk("br_ex_bubble_wreg", bus.ex_wreg, 0);
    chk("br_ex_bubble_alu_op", bus.ex_alu_op, 0);
    chk("br_mem_bubble_wreg", bus.mem_wreg, 0);
    chk("br_mem_bubble_branch", bus.mem_branch, 0);
    chk("br_flush_cnt", bus.flush_cnt, 1);
    chk("br_pc_src_clear", bus.pc_src, 0);
    nop();
    bus.mem_zero = 1'b0;
    step();

    // not-taken beq
    beq();
    step();
    add(5'd1, 5'd11);
    step();
    nop();
    #1;
    chk("nt_pc_src", bus.pc_src, 0);
    chk("nt_flush", bus.flush_if_id, 0);
    step();
    chk("nt_mem_wreg", bus.mem_wreg, 11);
    chk("nt_flush_cnt", bus.flush_cnt, 1);

    // lone jump
    jmp();
    #1;
    chk("j_flush", bus.flush_if_id, 1);
    step();
    chk("j_flush_cnt", bus.flush_cnt, 2);
    nop();
    #1;
    chk("j_flush_done", bus.flush_if_id, 0);
    step();

    // freeze during a stall
    lw(5'd8);
    step();
    add(5'd8, 5'd10);
    #1;
    chk("frz_stall", bus.stall, 1);
    enable = 1'b0;
    step();
    chk("frz_stall_held", bus.stall, 1);
    chk("frz_stall_cnt", bus.stall_cnt, 1);
    chk("frz_ex_mem_read", bus.ex_mem_read, 1);
    chk("frz_ex_wreg", bus.ex_wreg, 8);
    chk("frz_flush_cnt", bus.flush_cnt, 2);
    enable = 1'b1;
    step();
    chk("frz_resume_cnt", bus.stall_cnt, 2);
    chk("frz_resume_bubble", bus.ex_mem_read, 0);
    step();

    // five more load-use pairs: counter must stop at 3
    for (int i = 0; i < 5; i++) begin
      lw(5'd8);
      step();
      add(5'd8, 5'd12);
      #1;
      chk("sat_pair_stall", bus.stall, 1);
      step();
      step();
    end
    chk("sat_stall_cnt", bus.stall_cnt, 3);

    // asynchronous reset with a lw in EX and a stall pending
    lw(5'd8);
    step();
    add(5'd8, 5'd10);
    #1;
    chk("ar_stall_pre", bus.stall, 1);
    #1;
    arst_n = 1'b0;
    #1;
    chk("ar_ex_mem_read", bus.ex_mem_read, 0);
    chk("ar_ex_wreg", bus.ex_wreg, 0);
    chk("ar_stall", bus.stall, 0);
    chk("ar_mem_wreg", bus.mem_wreg, 0);
    chk("ar_stall_cnt", bus.stall_cnt, 0);
    chk("ar_flush_cnt", bus.flush_cnt, 0);
    @(negedge clk);
    arst_n = 1'b1;
    #1;
    chk("ar_post_stall", bus.stall, 0);
    step();
    chk("ar_post_ex_wreg", bus.ex_wreg, 10);
    chk("ar_post_stall_cnt", bus.stall_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/ctrl_pipeline.md
Name: ctrl_pipeline

Overview:
- Consumes the decoded control bundle produced in ID by the opcode decoder and carries it through the ID/EX, EX/MEM and MEM/WB pipeline registers of the 5-stage MIPS core.
- Detects load-use hazards and issues the stall.
- Applies jump and taken-branch flushes by inserting bubbles.
- Keeps saturating stall and flush event counters for performance analysis.

Parameters:
- CNT_W, 16, width of the stall_cnt and flush_cnt performance counters.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- arst_n  in  1  asynchronous active-low reset.
- enable  in  1  global pipeline advance; 0 freezes all registers and counters.
- id_valid  in  1  ID holds a real instruction.
- id_reg_dst, id_branch, id_mem_read, id_mem_2_reg, id_mem_write, id_alu_src, id_reg_write, id_jump  in  1 each  decoded controls from ID.
- id_alu_op  in  2  decoded ALU class: 0 add, 1 sub, 2 R-type.
- id_rs, id_rt, id_rd  in  5 each  register fields of the ID instruction.
- mem_zero  in  1  ALU zero flag registered into MEM.
- ex_alu_op  out  2  ID/EX control.
- ex_alu_src, ex_mem_read  out  1 each  ID/EX controls.
- ex_wreg  out  5  EX destination register.
- mem_branch, mem_mem_read, mem_mem_write  out  1 each  EX/MEM controls.
- mem_wreg  out  5  MEM destination register.
- wb_reg_write, wb_mem_2_reg  out  1 each  MEM/WB controls.
- wb_wreg  out  5  WB destination register.
- stall  out  1  hold PC and IF/ID.
- flush_if_id  out  1  zero IF/ID on the next edge.
- pc_src  out  1  select branch target.
- stall_cnt, flush_cnt  out  CNT_W each  saturating event counters.

Behaviour:
Reset
- While arst_n=0, every pipeline register, every output register and both counters are 0.
- This gives stall=0, flush_if_id=0 and pc_src=0.
- Reset takes effect immediately, including mid-stall or mid-flush. No pending hazard survives reset.

Pipeline advance (enable=1, rising edge)
- ID/EX loads the ID bundle.
- ex_wreg loads id_rd when id_reg_dst=1, otherwise id_rt.
- EX/MEM loads from ID/EX; MEM/WB loads from EX/MEM.
- Latency is one cycle per stage: an ID control appears on ex_* after 1 edge, mem_* after 2, and wb_* after 3.
- enable=0: all state holds. The combinational outputs below still evaluate from the held state.

Bubble
- A bubble loads all ID/EX controls and ex_wreg as 0.
- ID/EX takes a bubble when id_valid=0, stall=1, or pc_src=1.

Load-use stall (combinational)
- stall = ex_mem_read & (ex_wreg!=0) & id_valid & ~id_jump & (ex_wreg==id_rs | (ex_wreg==id_rt & (~id_alu_src | id_mem_write))).
- stall is forced to 0 when pc_src=1.
- A stall lasts exactly one cycle: after the bubble, ex_mem_read=0.

Branch and jump
- pc_src = mem_branch & mem_zero.
- When pc_src=1, EX/MEM also takes a bubble on that edge, squashing the EX instruction.
- flush_if_id = pc_src | (id_valid & id_jump & ~stall).
- Priority: pc_src > stall > jump.
- A jump in ID that coincides with pc_src is itself squashed and does not count as a separate flush.

Don't-care inputs
- Decoder don't-care values are registered as given.
- Bubbles always produce clean 0.

Counters
- stall_cnt increments on each enabled edge with stall=1.
- flush_cnt increments on each enabled edge with flush_if_id=1.
- Both saturate at 2^CNT_W-1; there is no wrap.

Test Plan:
- Reset mid-stream: assert arst_n=0 with a lw in EX -> all outputs read 0 immediately; after release, stall=0.
- R-type add (alu_op=2, reg_dst=1, rd=9) with id_valid=1 -> ex_wreg=9 after 1 edge, mem_wreg=9 after 2, then wb_wreg=9 with wb_reg_write=1 after 3.
- lw to rt=8 followed by add with rs=8 -> stall=1 for exactly one cycle; ex_* is zero the next cycle; stall_cnt=1; the add then proceeds. Repeat with rt=0 -> stall stays 0.
- beq reaching MEM with mem_zero=1 while ID holds a jump -> pc_src=1, flush_if_id=1, EX/MEM and ID/EX bubbled; flush_cnt increments by 1. Repeat with mem_zero=0 -> no flush.
- Jump in ID with no hazard -> flush_if_id=1 for one cycle, flush_cnt=1.
- Saturation: CNT_W=2 with 5 consecutive load-use pairs -> stall_cnt=3.
- enable=0 during a stall -> all registers and counters hold their values.
